// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction-fetch
// port (IF) and the load/store port (MEM). One bus transaction at a time, with
// alternating priority on contention and a timeout that aborts hung bus cycles.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ack_o,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [3:0]    mem_sel_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic [DW-1:0] mem_rdata_o,
    output logic          mem_ack_o,
    output logic          bus_cyc_o,
    output logic          bus_we_o,
    output logic [3:0]    bus_sel_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_ack_i,
    output logic          stallreq_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    // Last count value before a hung cycle is aborted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_mem;
    logic [7:0] cnt;

    // A requester being acked this cycle is masked so a held req is not
    // mistaken for a new transaction.
    logic if_act, mem_act, grant_if, grant_mem;

    assign if_act     = if_req_i & ~if_ack_o;
    assign mem_act    = mem_req_i & ~mem_ack_o;
    // MEM wins ties unless it won the previous grant, so IF cannot starve.
    assign grant_mem  = mem_act & (~if_act | ~last_mem);
    assign grant_if   = if_act & (~mem_act | last_mem);
    assign stallreq_o = if_act | mem_act;

    // Arbitration FSM with registered bus, ack, read data and error outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_mem    <= 1'b0;
            cnt         <= '0;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        bus_cyc_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        last_mem    <= 1'b1;
                        cnt         <= '0;
                        state       <= BUSY_MEM;
                    end else if (grant_if) begin
                        // Instruction fetch is always a full-word read.
                        bus_cyc_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'b1111;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                        last_mem    <= 1'b0;
                        cnt         <= '0;
                        state       <= BUSY_IF;
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (bus_ack_i) begin
                        if (state == BUSY_IF) begin
                            if_rdata_o <= bus_rdata_i;
                            if_ack_o   <= 1'b1;
                        end else begin
                            // Stores leave the load data register untouched.
                            if (!bus_we_o) begin
                                mem_rdata_o <= bus_rdata_i;
                            end
                            mem_ack_o <= 1'b1;
                        end
                        bus_cyc_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: complete the requester with zero data and flag it.
                        if (state == BUSY_IF) begin
                            if_rdata_o <= '0;
                            if_ack_o   <= 1'b1;
                        end else begin
                            mem_rdata_o <= '0;
                            mem_ack_o   <= 1'b1;
                        end
                        err_o     <= 1'b1;
                        bus_cyc_o <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_cyc_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        stallreq_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stallreq_o(stallreq_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        logic exp_mem;

        // Reset state
        step();
        chk("rst_cyc", 32'(bus_cyc_o), 0);
        chk("rst_ifack", 32'(if_ack_o), 0);
        chk("rst_memack", 32'(mem_ack_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_memrd", mem_rdata_o, 0);
        rst = 1'b1;
        step();

        // MEM load, ack one cycle after cyc rises
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h100;
        #1;
        chk("ld_stall0", 32'(stallreq_o), 1);
        step();
        chk("ld_cyc", 32'(bus_cyc_o), 1);
        chk("ld_addr", bus_addr_o, 32'h100);
        chk("ld_we", 32'(bus_we_o), 0);
        chk("ld_ack0", 32'(mem_ack_o), 0);
        chk("ld_stall1", 32'(stallreq_o), 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
        step();
        chk("ld_ack", 32'(mem_ack_o), 1);
        chk("ld_rdata", mem_rdata_o, 32'hDEADBEEF);
        chk("ld_cyc_off", 32'(bus_cyc_o), 0);
        chk("ld_stall_ack", 32'(stallreq_o), 0);
        mem_req_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        step();
        chk("ld_ack_pulse", 32'(mem_ack_o), 0);
        chk("ld_stall_after", 32'(stallreq_o), 0);

        // Stray ack while idle
        bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
        step();
        chk("stray_cyc", 32'(bus_cyc_o), 0);
        chk("stray_ack", 32'(mem_ack_o | if_ack_o), 0);
        chk("stray_err", 32'(err_o), 0);
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        step();

        // MEM store: bus fields held while busy, load data unchanged
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h200; mem_wdata_i = 32'h12345678;
        step();
        chk("st_cyc", 32'(bus_cyc_o), 1);
        chk("st_we", 32'(bus_we_o), 1);
        chk("st_sel", 32'(bus_sel_o), 32'h3);
        chk("st_addr", bus_addr_o, 32'h200);
        chk("st_wdata", bus_wdata_o, 32'h12345678);
        mem_wdata_i = '0; mem_addr_i = 32'hFFF0; mem_sel_i = 4'b1000;
        step();
        chk("st_hold_we", 32'(bus_we_o), 1);
        chk("st_hold_sel", 32'(bus_sel_o), 32'h3);
        chk("st_hold_addr", bus_addr_o, 32'h200);
        chk("st_hold_wdata", bus_wdata_o, 32'h12345678);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        step();
        chk("st_ack", 32'(mem_ack_o), 1);
        chk("st_rdata_kept", mem_rdata_o, 32'hDEADBEEF);
        chk("st_we_off", 32'(bus_we_o), 0);
        mem_req_i = 1'b0; bus_ack_i = 1'b0;
        mem_sel_i = 4'b0011;
        step();

        // IF read with req dropped mid-transaction; MEM inputs left as store
        if_req_i = 1'b1; if_addr_i = 32'h800;
        step();
        chk("ifr_cyc", 32'(bus_cyc_o), 1);
        chk("ifr_we", 32'(bus_we_o), 0);
        chk("ifr_sel", 32'(bus_sel_o), 32'hF);
        chk("ifr_addr", bus_addr_o, 32'h800);
        if_req_i = 1'b0;
        step();
        chk("ifr_cyc_held", 32'(bus_cyc_o), 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hA5A51234;
        step();
        chk("ifr_ack", 32'(if_ack_o), 1);
        chk("ifr_rdata", if_rdata_o, 32'hA5A51234);
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        step();
        chk("ifr_ack_pulse", 32'(if_ack_o), 0);

        // IF timeout: bus never acks
        if_req_i = 1'b1; if_addr_i = 32'h400;
        step();
        hi = bus_cyc_o ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!bus_cyc_o) break;
            hi++;
        end
        chk("to_cyc_len", 32'(hi), 15);
        chk("to_ack", 32'(if_ack_o), 1);
        chk("to_rdata", if_rdata_o, 0);
        chk("to_err", 32'(err_o), 1);
        if_req_i = 1'b0;
        step();
        chk("to_err_pulse", 32'(err_o), 0);
        chk("to_idle", 32'(bus_cyc_o), 0);

        // Contention, both held: MEM, IF, MEM, IF
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1100; mem_addr_i = 32'h300;
        if_req_i = 1'b1; if_addr_i = 32'h1000;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_mem = (k % 2 == 0);
            chk("ord_cyc", 32'(bus_cyc_o), 1);
            chk("ord_addr", bus_addr_o, exp_mem ? 32'h300 : 32'h1000);
            chk("ord_we", 32'(bus_we_o), 0);
            chk("ord_sel", 32'(bus_sel_o), exp_mem ? 32'hC : 32'hF);
            bus_ack_i = 1'b1; bus_rdata_i = 32'h11110000 + 32'(k);
            step();
            chk("ord_memack", 32'(mem_ack_o), exp_mem ? 1 : 0);
            chk("ord_ifack", 32'(if_ack_o), exp_mem ? 0 : 1);
            chk("ord_rdata", exp_mem ? mem_rdata_o : if_rdata_o, 32'h11110000 + 32'(k));
            bus_ack_i = 1'b0; bus_rdata_i = '0;
            if (k == 2) mem_req_i = 1'b0;
            if (k == 3) if_req_i = 1'b0;
            step();
        end
        chk("ord_done", 32'(bus_cyc_o), 0);

        // Reset three cycles into BUSY_MEM
        mem_req_i = 1'b1; mem_addr_i = 32'h500;
        step();
        chk("rb_cyc", 32'(bus_cyc_o), 1);
        step();
        step();
        rst = 1'b0; mem_req_i = 1'b0;
        #1;
        chk("rb_async_cyc", 32'(bus_cyc_o), 0);
        chk("rb_ack", 32'(mem_ack_o), 0);
        chk("rb_err", 32'(err_o), 0);
        step();
        chk("rb_held_ack", 32'(mem_ack_o | if_ack_o), 0);
        rst = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h900;
        step();
        chk("rb_if_cyc", 32'(bus_cyc_o), 1);
        chk("rb_if_addr", bus_addr_o, 32'h900);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
        step();
        chk("rb_if_ack", 32'(if_ack_o), 1);
        chk("rb_if_rdata", if_rdata_o, 32'h0BADF00D);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
